// File: rtl/fetch_ctrl.sv
// ============================================================================
// fetch_ctrl : IF-stage fetch sequencer (PC register, imem handshake, redirects)
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] npc,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic        if_valid,
  output logic        flush,
  output logic        imem_timeout
);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_KILL = 2'd3
  } state_t;

  localparam logic [4:0] c_TIMEOUT = 5'(TIMEOUT);

  state_t      r_state;
  logic        r_rst_q;
  logic [31:0] r_pc;
  logic [31:0] r_pend;
  logic        r_req;
  logic        r_if_valid;
  logic        r_flush;
  logic        r_timeout;
  logic [4:0]  r_wait;
  logic [4:0]  w_wait_next;

  // Reset asserts asynchronously but is released one clock later, so BOOT
  // only advances once the whole block has seen a clean edge out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rst_q <= 1'b1;
    else     r_rst_q <= 1'b0;
  end

  always_comb begin
    w_wait_next = r_wait;
    if (imem_ack)                 w_wait_next = 5'd0;
    else if (r_wait < c_TIMEOUT)  w_wait_next = r_wait + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_BOOT;
      r_pc       <= RESET_PC;
      r_pend     <= RESET_PC;
      r_req      <= 1'b0;
      r_if_valid <= 1'b0;
      r_flush    <= 1'b0;
      r_wait     <= 5'd0;
      r_timeout  <= 1'b0;
    end else begin
      r_flush    <= 1'b0;
      r_if_valid <= 1'b0;
      case (r_state)
        S_BOOT: begin
          if (!r_rst_q) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
        end
        S_REQ, S_KILL: begin
          r_wait <= w_wait_next;
          if (w_wait_next == c_TIMEOUT) r_timeout <= 1'b1;
          if (redirect) begin
            r_flush <= 1'b1;
            if (imem_ack) begin
              r_pc    <= redirect_pc;
              r_state <= S_REQ;
            end else begin
              // Address stays on the outstanding fetch until it is acked.
              r_pend  <= redirect_pc;
              r_state <= S_KILL;
            end
          end else if (imem_ack) begin
            if (r_state == S_KILL) begin
              r_pc    <= r_pend;
              r_state <= S_REQ;
            end else if (stall) begin
              r_if_valid <= 1'b1;
              r_req      <= 1'b0;
              r_state    <= S_HOLD;
            end else begin
              r_pc       <= npc;
              r_if_valid <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (redirect) begin
            r_pc    <= redirect_pc;
            r_flush <= 1'b1;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end else if (stall) begin
            r_if_valid <= 1'b1;
          end else begin
            r_pc    <= npc;
            r_req   <= 1'b1;
            r_state <= S_REQ;
          end
        end
        default: begin
          r_state <= S_BOOT;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign pc           = r_pc;
  assign imem_addr    = r_pc;
  assign imem_req     = r_req;
  assign if_valid     = r_if_valid;
  assign flush        = r_flush;
  assign imem_timeout = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// tb_fetch_ctrl : randomized + directed scoreboard bench for fetch_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

  localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
  localparam int          c_TIMEOUT  = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] npc = '0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_ack = 1'b0;
  logic [31:0] pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_valid;
  logic        flush;
  logic        imem_timeout;

  fetch_ctrl #(.RESET_PC(c_RESET_PC), .TIMEOUT(c_TIMEOUT)) dut (
    .clk(clk), .rst(rst), .npc(npc), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_ack(imem_ack), .pc(pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .if_valid(if_valid), .flush(flush),
    .imem_timeout(imem_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        req;
    logic        ifv;
    logic        fl;
    logic        to;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: fetch is either requesting or holding a stalled
  // instruction; a requesting fetch may have its response marked for discard.
  logic [31:0] m_pc, m_pend;
  bit          m_req, m_ifv, m_fl, m_to, m_hold, m_disc;
  int          m_wait, m_boot;

  task automatic m_reset();
    m_pc = c_RESET_PC; m_pend = c_RESET_PC;
    m_req = 0; m_ifv = 0; m_fl = 0; m_to = 0; m_hold = 0; m_disc = 0;
    m_wait = 0; m_boot = 2;
  endtask

  task automatic model_edge();
    if (rst) begin m_reset(); return; end
    m_ifv = 0; m_fl = 0;
    if (m_boot > 0) begin
      m_boot--;
      if (m_boot == 0) m_req = 1;
      return;
    end
    if (m_hold) begin
      if (redirect) begin m_pc = redirect_pc; m_fl = 1; m_hold = 0; m_req = 1; end
      else if (stall) m_ifv = 1;
      else begin m_pc = npc; m_hold = 0; m_req = 1; end
      return;
    end
    m_wait = imem_ack ? 0 : ((m_wait < c_TIMEOUT) ? m_wait + 1 : m_wait);
    if (m_wait == c_TIMEOUT) m_to = 1;
    if (redirect) begin
      m_fl = 1;
      if (imem_ack) begin m_pc = redirect_pc; m_disc = 0; end
      else begin m_pend = redirect_pc; m_disc = 1; end
    end else if (imem_ack) begin
      if (m_disc) begin m_pc = m_pend; m_disc = 0; end
      else if (stall) begin m_ifv = 1; m_hold = 1; m_req = 0; end
      else begin m_pc = npc; m_ifv = 1; end
    end
  endtask

  function automatic exp_t m_snap();
    exp_t e;
    e.pc = m_pc; e.req = m_req; e.ifv = m_ifv; e.fl = m_fl; e.to = m_to;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_all(input string tag, input exp_t e);
    chk({tag, ".pc"},           pc,                   e.pc);
    chk({tag, ".imem_addr"},    imem_addr,            e.pc);
    chk({tag, ".imem_req"},     {31'd0, imem_req},     {31'd0, e.req});
    chk({tag, ".if_valid"},     {31'd0, if_valid},     {31'd0, e.ifv});
    chk({tag, ".flush"},        {31'd0, flush},        {31'd0, e.fl});
    chk({tag, ".imem_timeout"}, {31'd0, imem_timeout}, {31'd0, e.to});
  endtask

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic step(input bit r, input bit a, input bit s, input bit d,
                      input logic [31:0] rp, input logic [31:0] np);
    bit rose;
    @(negedge clk); #1;
    rose = r && !rst;
    rst = r; imem_ack = a; stall = s; redirect = d; redirect_pc = rp; npc = np;
    if (rose) begin
      m_reset();
      #1;
      cmp_all("async_reset", m_snap());
    end
    model_edge();
    q.push_back(m_snap());
  endtask

  function automatic logic [31:0] nx();
    return m_pc + 32'd4;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        cmp_all("cycle", e);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    m_reset();
    #2;
    cmp_all("reset_state", m_snap());
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    // release; acks during boot must be ignored
    step(0, 1, 0, 1, 32'h55, 32'h99);
    step(0, 1, 0, 0, 0, 32'h77);
    // sequential fetch 0,4,8 then stalled ack at 8
    step(0, 1, 0, 0, 0, nx());
    step(0, 1, 0, 0, 0, nx());
    step(0, 1, 1, 0, 0, nx());
    step(0, 0, 1, 0, 0, nx());
    step(0, 0, 1, 0, 0, nx());
    step(0, 0, 0, 0, 0, nx());
    step(0, 1, 0, 0, 0, nx());
    // redirect without ack at 0x10, ack two cycles later is discarded
    step(0, 0, 0, 1, 32'h100, nx());
    step(0, 0, 0, 0, 0, nx());
    step(0, 1, 0, 0, 0, nx());
    // KILL re-redirect coincident with ack
    step(0, 0, 0, 1, 32'h180, nx());
    step(0, 1, 0, 1, 32'h200, nx());
    // HOLD with redirect and stall together
    step(0, 1, 1, 0, 0, nx());
    step(0, 0, 1, 1, 32'h300, nx());
    // withheld ack -> sticky timeout
    repeat (20) step(0, 0, 0, 0, 0, nx());
    repeat (3) step(0, 1, 0, 0, 0, nx());
    step(0, 0, 0, 0, 0, nx());
    step(1, 1, 0, 0, 0, nx());
    step(1, 0, 0, 0, 0, nx());
    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit r, a, s, d;
      logic [31:0] np;
      r  = (rst && $urandom_range(0, 99) < 60) || ($urandom_range(0, 199) < 2);
      a  = $urandom_range(0, 99) < 55;
      s  = $urandom_range(0, 99) < 35;
      d  = $urandom_range(0, 99) < 12;
      np = ($urandom_range(0, 3) == 0) ? 32'($urandom) : nx();
      step(r, a, s, d, 32'($urandom), np);
    end
    step(0, 0, 0, 0, 0, nx());
    @(posedge clk); #3;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
